tc_seq_ctrl: RTL and testbench

Parametrised tile-loop sequencer for the tensor-core datapath. It replaces the fixed 16×16×16 control unit. It walks the (k, m, n) tile space for runtime-selectable K depth and issues one tile operation per cycle. It tracks in-flight tiles through a PIPE_LAT-deep pipeline and stalls on read-after-write hazards on the D/C tile buffer. It then drains the result rows with a ready/valid handshake. It sits between the host command interface and the A/B/D buffer pointer inputs.

---
 rtl/tc_seq_ctrl.sv | 96 +++++++++
 tb/tb_tc_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tc_seq_ctrl.sv
// tc_seq_ctrl: tile-loop sequencer with read-after-write hazard stalls and ready/valid row drain
module tc_seq_ctrl #(
  parameter int M        = 16,
  parameter int N        = 16,
  parameter int K        = 16,
  parameter int TILE_M   = 4,
  parameter int TILE_N   = 4,
  parameter int TILE_K   = 4,
  parameter int PIPE_LAT = 3,
  parameter int DW_PTR   = 2,
  parameter int DW_IDX   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                acc_mode,
  input  logic [DW_PTR:0]     k_tiles,
  output logic                busy,
  output logic [DW_PTR-1:0]   ptr_m,
  output logic [DW_PTR-1:0]   ptr_n,
  output logic [DW_PTR-1:0]   ptr_k,
  output logic                issue_valid,
  output logic                psum_zero,
  output logic                write_d,
  output logic [2*DW_PTR-1:0] ptr_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW_IDX-1:0]   row_out,
  output logic                done
);
  localparam int TM = M / TILE_M;
  localparam int TN = N / TILE_N;
  localparam int TK = K / TILE_K;
  localparam logic [DW_PTR:0] TK_W = (DW_PTR+1)'(TK);
  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DW_PTR-1:0] m_q, n_q, k_q;
  logic [DW_PTR:0] kt_q;
  logic acc_q, done_q, hazard, n_wrap, m_wrap, last_issue, drain_last;
  logic [DW_IDX-1:0] row_q;
  logic [PIPE_LAT-1:0] pv_q;
  logic [2*DW_PTR-1:0] pt_q [PIPE_LAT];
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++)
      if (pv_q[i] && pt_q[i] == {m_q, n_q}) hazard = 1'b1;
  end
  assign issue_valid = state_q == COMPUTE && !hazard;
  assign n_wrap      = n_q == DW_PTR'(TN - 1);
  assign m_wrap      = m_q == DW_PTR'(TM - 1);
  assign last_issue  = issue_valid && n_wrap && m_wrap && {1'b0, k_q} == kt_q - 1'b1;
  assign drain_last  = state_q == DRAIN && out_ready && row_q == DW_IDX'(M - 1);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && start)     ? COMPUTE :
              last_issue                     ? FLUSH   :
              (state_q == FLUSH && ~|pv_q)   ? DRAIN   :
              drain_last                     ? IDLE    : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {m_q, n_q, k_q, kt_q, acc_q, done_q, row_q, pv_q} <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_last;
      pv_q[0] <= issue_valid;
      pt_q[0] <= {m_q, n_q};
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
      if (state_q == IDLE && start) begin
        kt_q  <= (k_tiles == '0 || k_tiles > TK_W) ? TK_W : k_tiles;
        acc_q <= acc_mode;
        {m_q, n_q, k_q} <= '0;
      end
      // counters return to zero after the final issue so idle pointers read 0
      if (issue_valid) begin
        n_q <= n_wrap ? '0 : n_q + 1'b1;
        if (n_wrap) m_q <= m_wrap ? '0 : m_q + 1'b1;
        if (n_wrap && m_wrap) k_q <= last_issue ? '0 : k_q + 1'b1;
      end
      if (state_q == DRAIN && out_ready) row_q <= drain_last ? '0 : row_q + 1'b1;
    end
  end
  assign busy      = state_q != IDLE;
  assign {ptr_m, ptr_n, ptr_k} = {m_q, n_q, k_q};
  assign psum_zero = issue_valid && k_q == '0 && !acc_q;
  assign write_d   = pv_q[PIPE_LAT-1];
  assign ptr_d     = pt_q[PIPE_LAT-1];
  assign out_valid = state_q == DRAIN;
  assign row_out   = row_q;
  assign done      = done_q;
endmodule

// File: tb/tb_tc_seq_ctrl.sv
// tb_tc_seq_ctrl: randomized jobs on the default sequencer against a loop-order model, plus a single-tile stall instance
module tb_tc_seq_ctrl;
  logic clk = 0, reset = 0;
  logic start = 0, acc_mode = 0, out_ready = 0;
  logic [2:0] k_tiles = 0;
  logic busy, issue_valid, psum_zero, write_d, out_valid, done;
  logic [1:0] ptr_m, ptr_n, ptr_k;
  logic [3:0] ptr_d, row_out;
  logic s_start = 0, s_acc = 0, s_ready = 0;
  logic [2:0] s_k = 0;
  logic s_busy, s_iv, s_pz, s_wd, s_ov, s_done;
  logic [1:0] s_pm, s_pn, s_pk, s_row;
  logic [3:0] s_pd;
  logic [19:0] all_out;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  tc_seq_ctrl dut (.clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode), .k_tiles(k_tiles),
    .busy(busy), .ptr_m(ptr_m), .ptr_n(ptr_n), .ptr_k(ptr_k), .issue_valid(issue_valid),
    .psum_zero(psum_zero), .write_d(write_d), .ptr_d(ptr_d), .out_valid(out_valid),
    .out_ready(out_ready), .row_out(row_out), .done(done));

  tc_seq_ctrl #(.M(4), .N(4), .K(16), .TILE_M(4), .TILE_N(4), .TILE_K(4), .PIPE_LAT(3),
    .DW_PTR(2), .DW_IDX(2)) dut2 (.clk(clk), .reset(reset), .start(s_start), .acc_mode(s_acc),
    .k_tiles(s_k), .busy(s_busy), .ptr_m(s_pm), .ptr_n(s_pn), .ptr_k(s_pk), .issue_valid(s_iv),
    .psum_zero(s_pz), .write_d(s_wd), .ptr_d(s_pd), .out_valid(s_ov), .out_ready(s_ready),
    .row_out(s_row), .done(s_done));

  assign all_out = {busy, issue_valid, psum_zero, write_d, ptr_m, ptr_n, ptr_k, ptr_d, out_valid, row_out, done};

  task automatic test_reset();
    n_checks++;
    if (all_out !== 20'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    n_checks++;
    if ({s_busy, s_iv, s_wd, s_ov, s_done, s_row} !== 7'h0) begin
      n_fail++; $display("FAIL reset_outputs_small got=%b exp=0", {s_busy, s_iv, s_wd, s_ov, s_done, s_row});
    end
  endtask

  // model: issues follow k-m-n nested loops one per cycle; each write lands 3 cycles later
  task automatic run_job(input bit acc, input int kt_in, input int rmode, input bit poke);
    int kt, n_iss, idx, exp_row, cyc, pat, flush_wait, kk, mm, nn;
    int wdue[$];
    logic [3:0] wtag[$];
    bit fin, exp_wd;
    kt = (kt_in == 0 || kt_in > 4) ? 4 : kt_in;
    n_iss = kt * 16; idx = 0; exp_row = 0; pat = 0; flush_wait = 0; fin = 0;
    @(negedge clk); start = 1; acc_mode = acc; k_tiles = 3'(kt_in);
    @(negedge clk); start = 0; acc_mode = ~acc; k_tiles = 3'($urandom);
    cyc = 1;
    while (!fin && cyc < 400) begin
      exp_wd = wdue.size() > 0 && wdue[0] == cyc;
      n_checks++;
      if (write_d !== exp_wd || (exp_wd && ptr_d !== wtag[0])) begin
        n_fail++; $display("FAIL write_d cyc=%0d got=%b/%h exp=%b/%h", cyc, write_d, ptr_d, exp_wd, exp_wd ? wtag[0] : 4'h0);
      end
      if (exp_wd) begin void'(wdue.pop_front()); void'(wtag.pop_front()); end
      n_checks++;
      if (idx < n_iss) begin
        kk = idx / 16; mm = (idx / 4) % 4; nn = idx % 4;
        if ({issue_valid, psum_zero, ptr_k, ptr_m, ptr_n} !== {1'b1, kk == 0 && !acc, 2'(kk), 2'(mm), 2'(nn)}) begin
          n_fail++; $display("FAIL issue idx=%0d got v=%b z=%b k%0d m%0d n%0d exp k%0d m%0d n%0d z=%b",
            idx, issue_valid, psum_zero, ptr_k, ptr_m, ptr_n, kk, mm, nn, kk == 0 && !acc);
        end
        wdue.push_back(cyc + 3); wtag.push_back({2'(mm), 2'(nn)});
        idx++;
      end else if ({issue_valid, psum_zero} !== 2'b00) begin
        n_fail++; $display("FAIL no_issue cyc=%0d got=%b exp=00", cyc, {issue_valid, psum_zero});
      end
      n_checks++;
      if (exp_row == 16) begin
        if ({done, busy, out_valid} !== 3'b100) begin
          n_fail++; $display("FAIL done_pulse got done/busy/ov=%b exp=100", {done, busy, out_valid});
        end
        fin = 1;
      end else if ({done, busy} !== 2'b01) begin
        n_fail++; $display("FAIL busy cyc=%0d got done/busy=%b exp=01", cyc, {done, busy});
      end else if (out_valid) begin
        n_checks++;
        if (idx != n_iss || wdue.size() != 0 || row_out !== 4'(exp_row)) begin
          n_fail++; $display("FAIL drain_row cyc=%0d got=%0d exp=%0d pending=%0d", cyc, row_out, exp_row, wdue.size());
        end
      end else if (idx == n_iss && wdue.size() == 0) begin
        flush_wait++;
        if (flush_wait == 4) begin n_fail++; $display("FAIL flush_to_drain got=stuck exp=drain within 3"); end
      end
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (pat % 3 == 0) : 1'($urandom);
      if (out_valid) pat++;
      start = poke && !fin && (cyc == 10 || (out_valid && exp_row == 2));
      if (out_valid && out_ready) exp_row++;
      @(negedge clk); cyc++;
    end
    start = 0;
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL job_timeout got=no_done exp=done"); end
    else if (all_out !== 20'h0) begin n_fail++; $display("FAIL post_done_idle got=%h exp=0", all_out); end
  endtask

  task automatic test_abort();
    @(negedge clk); start = 1; acc_mode = 0; k_tiles = 4;
    @(negedge clk); start = 0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL abort_issue cyc=%0d got=%b exp=1", c, issue_valid); end
      if (c < 3) @(negedge clk);
    end
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (all_out !== 20'h0) begin n_fail++; $display("FAIL abort_outputs got=%h exp=0", all_out); end
    reset = 1;
    @(negedge clk);
    n_checks++;
    if (all_out !== 20'h0) begin n_fail++; $display("FAIL abort_stays_idle got=%h exp=0", all_out); end
    run_job(0, 4, 0, 0);
  endtask

  // single tile: each repeated issue waits until its previous write has left the pipeline
  task automatic test_stall();
    int next, cnt, wd_due, rows, cyc;
    bit exp_iv;
    @(negedge clk); s_start = 1; s_k = 4; s_acc = 0; s_ready = 1;
    @(negedge clk); s_start = 0;
    next = 1; cnt = 0; wd_due = -1;
    for (cyc = 1; cyc <= 17; cyc++) begin
      exp_iv = cnt < 4 && cyc == next;
      n_checks++;
      if (s_iv !== exp_iv || s_wd !== (cyc == wd_due) || (exp_iv && s_pk !== 2'(cnt))) begin
        n_fail++; $display("FAIL stall cyc=%0d got iv/wd/k=%b/%b/%0d exp=%b/%b/%0d", cyc, s_iv, s_wd, s_pk, exp_iv, cyc == wd_due, cnt);
      end
      if (exp_iv) begin wd_due = cyc + 3; next = wd_due + 1; cnt++; end
      @(negedge clk);
    end
    rows = 0;
    for (cyc = 0; cyc < 20 && rows < 4; cyc++) begin
      if (s_ov) begin
        n_checks++;
        if (s_row !== 2'(rows)) begin n_fail++; $display("FAIL stall_row got=%0d exp=%0d", s_row, rows); end
        rows++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (rows != 4 || {s_done, s_busy} !== 2'b10) begin
      n_fail++; $display("FAIL stall_done rows=%0d got done/busy=%b exp=4 rows, 10", rows, {s_done, s_busy});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1;
    run_job(0, 4, 0, 0);
    run_job(1, 0, 0, 0);
    run_job(0, 4, 1, 0);
    run_job(0, 2, 0, 1);
    test_abort();
    for (int j = 0; j < 4; j++) run_job(1'($urandom), int'($urandom_range(0, 7)), 2, 1'($urandom));
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
